// File: rtl/branch_pc_unit.sv
// ============================================================================
// branch_pc_unit: architectural PC, carry flag and branch resolution.
// Optional wrong-path flush is enabled by defining BRANCH_FLUSH_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_pc_unit #(
  parameter int              PC_W     = 32,
  parameter int              OFF_W    = 26,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic             stall,
  input  logic [3:0]       BranchOp,
  input  logic [OFF_W-1:0] offset,
  input  logic [PC_W-1:0]  rs_val,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic             alu_carry,
  input  logic             carry_we,
  output logic [PC_W-1:0]  pc,
  output logic             taken,
  output logic             kill,
  output logic             link_we,
  output logic [PC_W-1:0]  link_data,
  output logic             carry_q,
  output logic             bad_op
);

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_B    = 4'd1;
  localparam logic [3:0] OP_BL   = 4'd2;
  localparam logic [3:0] OP_BCY  = 4'd3;
  localparam logic [3:0] OP_BNCY = 4'd4;
  localparam logic [3:0] OP_BR   = 4'd5;
  localparam logic [3:0] OP_BLTZ = 4'd6;
  localparam logic [3:0] OP_BZ   = 4'd7;
  localparam logic [3:0] OP_BNZ  = 4'd8;

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] link_data_q, link_data_d;
  logic            taken_q, taken_d;
  logic            link_we_q, link_we_d;
  logic            carry_flag_q, carry_flag_d;
  logic            bad_op_q, bad_op_d;
  logic            in_flush;
  logic            go_flush;

`ifdef BRANCH_FLUSH_EN
  typedef enum logic [0:0] {RUN = 1'b0, FLUSH = 1'b1} state_t;
  state_t state_q, state_d;
  assign in_flush = (state_q == FLUSH);
`else
  assign in_flush = 1'b0;
`endif

  logic            accept;
  logic            cond;
  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] rel_tgt;
  logic [PC_W-1:0] off_sext;

  assign off_sext = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign seq_pc   = pc_q + PC_W'(4);
  assign rel_tgt  = pc_q + off_sext;
  assign accept   = instr_valid & ~stall & ~in_flush;

  always_comb begin
    cond = 1'b0;
    case (BranchOp)
      OP_B, OP_BL, OP_BR: cond = 1'b1;
      OP_BCY:  cond = carry_flag_q;
      OP_BNCY: cond = ~carry_flag_q;
      OP_BLTZ: cond = alu_neg;
      OP_BZ:   cond = alu_zero;
      OP_BNZ:  cond = ~alu_zero;
      OP_NONE: cond = 1'b0;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    pc_d         = pc_q;
    link_data_d  = link_data_q;
    carry_flag_d = carry_flag_q;
    bad_op_d     = bad_op_q;
    taken_d      = 1'b0;
    link_we_d    = 1'b0;
    go_flush     = 1'b0;
    if (accept) begin
      if (cond) begin
        pc_d     = (BranchOp == OP_BR) ? rs_val : rel_tgt;
        taken_d  = 1'b1;
        go_flush = 1'b1;
      end else begin
        pc_d = seq_pc;
      end
      if (BranchOp == OP_BL) begin
        link_we_d   = 1'b1;
        link_data_d = seq_pc;
      end
      if (BranchOp > OP_BNZ) begin
        bad_op_d = 1'b1;
      end
      // Branch condition above already used the pre-update carry.
      if (carry_we) begin
        carry_flag_d = alu_carry;
      end
    end
  end

`ifdef BRANCH_FLUSH_EN
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (go_flush) state_d = FLUSH;
      FLUSH:   if (!stall)   state_d = RUN;
      default: state_d = RUN;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      link_data_q  <= '0;
      taken_q      <= 1'b0;
      link_we_q    <= 1'b0;
      carry_flag_q <= 1'b0;
      bad_op_q     <= 1'b0;
`ifdef BRANCH_FLUSH_EN
      state_q      <= RUN;
`endif
    end else begin
      pc_q         <= pc_d;
      link_data_q  <= link_data_d;
      taken_q      <= taken_d;
      link_we_q    <= link_we_d;
      carry_flag_q <= carry_flag_d;
      bad_op_q     <= bad_op_d;
`ifdef BRANCH_FLUSH_EN
      state_q      <= state_d;
`endif
    end
  end

`ifndef BRANCH_FLUSH_EN
  logic unused_go_flush;
  assign unused_go_flush = go_flush;
`endif

  assign pc        = pc_q;
  assign taken     = taken_q;
  assign kill      = in_flush;
  assign link_we   = link_we_q;
  assign link_data = link_data_q;
  assign carry_q   = carry_flag_q;
  assign bad_op    = bad_op_q;

endmodule

`default_nettype wire
